// File: rtl/fpg8_pkg.sv
// Shared definitions for the boot loader: FSM states, frame constants and the
// word-count decode used when the count byte arrives.
package fpg8_pkg;

  typedef enum logic [2:0] {
    WAIT_CNT,
    WAIT_HI,
    WAIT_LO,
    WAIT_CSUM,
    DONE,
    ERROR
  } loader_state_t;

  localparam int BYTES_PER_WORD   = 2;
  localparam int COUNT_ZERO_MEANS = 256;
  localparam int WORD_BITS        = BYTES_PER_WORD * 8;
  localparam int COUNT_BITS       = $clog2(COUNT_ZERO_MEANS + 1);

  // A count byte of zero stands for a full 256-word image.
  function automatic logic [COUNT_BITS-1:0] decode_count(input logic [7:0] count_byte);
    if (count_byte == 8'd0) begin
      return COUNT_BITS'(COUNT_ZERO_MEANS);
    end
    return COUNT_BITS'(count_byte);
  endfunction

endpackage

// File: rtl/ram_loader_if.sv
// Byte-stream input, RAM write port and status lines of the program loader.
interface ram_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  rx_valid;
  logic [7:0]            rx_byte;
  logic                  rearm;
  logic                  ld_w_en;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  cpu_hold;
  logic                  done;
  logic                  error;

  modport master (
    output rx_valid, rx_byte, rearm,
    input  ld_w_en, ld_addr, ld_data, cpu_hold, done, error
  );

  modport slave (
    input  rx_valid, rx_byte, rearm,
    output ld_w_en, ld_addr, ld_data, cpu_hold, done, error
  );
endinterface

// File: rtl/byte_gap_timer.sv
// Idle counter that flags when TIMEOUT_CYCLES consecutive enabled cycles pass
// without a clear; shared with the UART receiver.
module byte_gap_timer #(
  parameter int TIMEOUT_CYCLES = 1200000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // Saturates at the limit so a stalled enable never wraps back to zero.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != CW'(TIMEOUT_CYCLES))) begin
      count <= count + CW'(1);
    end
  end

  // Fires on the edge whose increment would reach the limit; a clear always wins.
  assign expired = enable && !clear && (count >= CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ram_loader.sv
// Boot loader: assembles big-endian words from the UART byte stream, writes
// them to RAM from address 0 and releases the CPU once the checksum matches.
module ram_loader
  import fpg8_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1200000
) (
  input  logic          clk,
  input  logic          reset,
  ram_loader_if.slave   bus
);

  loader_state_t         state;
  logic [COUNT_BITS-1:0] num_words;
  logic [COUNT_BITS-1:0] word_cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            hi_byte;
  logic [7:0]            csum;
  logic                  ld_w_en_q;
  logic [ADDR_WIDTH-1:0] ld_addr_q;
  logic [DATA_WIDTH-1:0] ld_data_q;
  logic                  cpu_hold_q;
  logic                  done_q;
  logic                  error_q;
  logic                  in_frame;
  logic                  gap_expired;
  logic [WORD_BITS-1:0]  assembled;

  assign in_frame  = (state == WAIT_HI) || (state == WAIT_LO) || (state == WAIT_CSUM);
  assign assembled = {hi_byte, bus.rx_byte};

  byte_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (bus.rx_valid || !in_frame),
    .enable (in_frame),
    .expired(gap_expired)
  );

  // The byte strobe is checked before the gap timer so a byte landing on the
  // expiry edge still counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WAIT_CNT;
      num_words  <= '0;
      word_cnt   <= '0;
      addr       <= '0;
      hi_byte    <= '0;
      csum       <= '0;
      ld_w_en_q  <= 1'b0;
      ld_addr_q  <= '0;
      ld_data_q  <= '0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      ld_w_en_q <= 1'b0;
      unique case (state)
        WAIT_CNT: begin
          if (bus.rx_valid) begin
            num_words <= decode_count(bus.rx_byte);
            word_cnt  <= '0;
            addr      <= '0;
            csum      <= '0;
            state     <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (bus.rx_valid) begin
            hi_byte <= bus.rx_byte;
            csum    <= csum + bus.rx_byte;
            state   <= WAIT_LO;
          end else if (gap_expired) begin
            error_q <= 1'b1;
            state   <= ERROR;
          end
        end
        WAIT_LO: begin
          if (bus.rx_valid) begin
            csum      <= csum + bus.rx_byte;
            ld_w_en_q <= 1'b1;
            ld_addr_q <= addr;
            ld_data_q <= DATA_WIDTH'(assembled);
            addr      <= addr + ADDR_WIDTH'(1);
            word_cnt  <= word_cnt + COUNT_BITS'(1);
            state     <= (word_cnt == num_words - COUNT_BITS'(1)) ? WAIT_CSUM : WAIT_HI;
          end else if (gap_expired) begin
            error_q <= 1'b1;
            state   <= ERROR;
          end
        end
        WAIT_CSUM: begin
          if (bus.rx_valid) begin
            if (bus.rx_byte == csum) begin
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
              state      <= DONE;
            end else begin
              error_q <= 1'b1;
              state   <= ERROR;
            end
          end else if (gap_expired) begin
            error_q <= 1'b1;
            state   <= ERROR;
          end
        end
        DONE, ERROR: begin
          if (bus.rearm) begin
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            cpu_hold_q <= 1'b1;
            state      <= WAIT_CNT;
          end
        end
        default: state <= WAIT_CNT;
      endcase
    end
  end

  assign bus.ld_w_en  = ld_w_en_q;
  assign bus.ld_addr  = ld_addr_q;
  assign bus.ld_data  = ld_data_q;
  assign bus.cpu_hold = cpu_hold_q;
  assign bus.done     = done_q;
  assign bus.error    = error_q;

endmodule

// File: tb/tb_ram_loader.sv
// Directed frames into ram_loader; expected RAM writes go to a scoreboard that
// a negedge monitor drains, status lines are compared inline.
module tb_ram_loader;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic       clk;
  logic       reset;
  int         compared;
  int         mismatched;
  int         writesSeen;
  wr_t        sb[$];
  logic [7:0] frame[$];

  ram_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

  ram_loader #(
    .ADDR_WIDTH    (8),
    .DATA_WIDTH    (16),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic expectWrite(input logic [7:0] a, input logic [15:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    sb.push_back(w);
  endtask

  // Sends the queued frame, either one idle cycle between bytes or back to back.
  task automatic applyStimulus(input bit backToBack);
    foreach (frame[i]) begin
      @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_byte  = frame[i];
      if (!backToBack) begin
        @(negedge clk);
        bus.rx_valid = 1'b0;
      end
    end
    if (backToBack) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
    end
    frame.delete();
  endtask

  task automatic rearmPulse();
    @(negedge clk);
    bus.rearm = 1'b1;
    @(negedge clk);
    bus.rearm = 1'b0;
  endtask

  task automatic checkStatus(input string tag, input bit expHold, input bit expDone, input bit expErr);
    checkOutput({tag, "_cpu_hold"}, int'(bus.cpu_hold), int'(expHold));
    checkOutput({tag, "_done"}, int'(bus.done), int'(expDone));
    checkOutput({tag, "_error"}, int'(bus.error), int'(expErr));
  endtask

  // Every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (bus.ld_w_en === 1'b1) begin
      writesSeen++;
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", bus.ld_addr, bus.ld_data);
      end else begin
        wr_t w;
        w = sb.pop_front();
        checkOutput("write_addr", int'(bus.ld_addr), int'(w.addr));
        checkOutput("write_data", int'(bus.ld_data), int'(w.data));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compared     = 0;
    mismatched   = 0;
    writesSeen   = 0;
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    bus.rearm    = 1'b0;

    repeat (2) @(negedge clk);
    checkStatus("reset", 1'b1, 1'b0, 1'b0);
    checkOutput("reset_w_en", int'(bus.ld_w_en), 0);
    checkOutput("reset_addr", int'(bus.ld_addr), 0);
    checkOutput("reset_data", int'(bus.ld_data), 0);
    reset = 1'b0;

    $display("[TB] two-word frame");
    // 0x12+0x34+0xAB+0xCD = 0x1BE, so the valid checksum byte is 0xBE.
    expectWrite(8'h00, 16'h1234);
    expectWrite(8'h01, 16'hABCD);
    frame = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    applyStimulus(1'b0);
    checkStatus("pre_csum", 1'b1, 1'b0, 1'b0);
    frame = '{8'hBE};
    applyStimulus(1'b0);
    checkStatus("good_frame", 1'b0, 1'b1, 1'b0);
    checkOutput("good_frame_drained", sb.size(), 0);
    @(negedge clk);
    frame = '{8'h55};
    applyStimulus(1'b0);
    checkStatus("done_ignores_rx", 1'b0, 1'b1, 1'b0);

    $display("[TB] bad checksum");
    rearmPulse();
    checkStatus("rearm_from_done", 1'b1, 1'b0, 1'b0);
    writesSeen = 0;
    expectWrite(8'h00, 16'h1234);
    expectWrite(8'h01, 16'hABCD);
    frame = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h0F};
    applyStimulus(1'b0);
    checkStatus("bad_csum", 1'b1, 1'b0, 1'b1);
    checkOutput("bad_csum_writes", writesSeen, 2);

    $display("[TB] 256-word frame");
    rearmPulse();
    checkStatus("rearm_from_error", 1'b1, 1'b0, 1'b0);
    writesSeen = 0;
    frame.push_back(8'h00);
    for (int i = 0; i < 256; i++) begin
      expectWrite(8'(i), 16'h0101);
      frame.push_back(8'h01);
      frame.push_back(8'h01);
    end
    frame.push_back(8'h00);
    applyStimulus(1'b0);
    checkStatus("full_frame", 1'b0, 1'b1, 1'b0);
    checkOutput("full_frame_writes", writesSeen, 256);
    checkOutput("full_frame_drained", sb.size(), 0);

    $display("[TB] byte gap timeout");
    rearmPulse();
    frame = '{8'h01, 8'h55};
    applyStimulus(1'b0);
    repeat (49) @(negedge clk);
    checkStatus("gap_49", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkStatus("gap_50", 1'b1, 1'b0, 1'b1);
    rearmPulse();
    checkStatus("rearm_after_timeout", 1'b1, 1'b0, 1'b0);
    expectWrite(8'h00, 16'h7788);
    frame = '{8'h01, 8'h77, 8'h88, 8'hFF};
    applyStimulus(1'b0);
    checkStatus("after_timeout_frame", 1'b0, 1'b1, 1'b0);

    $display("[TB] reset mid-frame");
    rearmPulse();
    expectWrite(8'h00, 16'h1122);
    expectWrite(8'h01, 16'h3344);
    frame = '{8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    applyStimulus(1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkStatus("mid_reset", 1'b1, 1'b0, 1'b0);
    checkOutput("mid_reset_w_en", int'(bus.ld_w_en), 0);
    checkOutput("mid_reset_addr", int'(bus.ld_addr), 0);
    checkOutput("mid_reset_data", int'(bus.ld_data), 0);
    expectWrite(8'h00, 16'hBEEF);
    frame = '{8'h01, 8'hBE, 8'hEF, 8'hAD};
    applyStimulus(1'b0);
    checkStatus("post_reset_frame", 1'b0, 1'b1, 1'b0);

    $display("[TB] back-to-back frame");
    rearmPulse();
    writesSeen = 0;
    expectWrite(8'h00, 16'h0102);
    expectWrite(8'h01, 16'h0304);
    expectWrite(8'h02, 16'h0506);
    frame = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h15};
    applyStimulus(1'b1);
    checkStatus("burst_frame", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("burst_writes", writesSeen, 3);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
